// File: rtl/gray_pkg.sv
// Shared types and constants for the gray-image memory arbiter and its helpers.
package gray_pkg;

   localparam int IMG_W  = 128;
   localparam int ADDR_W = 14;
   localparam int PIX_W  = 8;

   typedef logic client_id_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_t;

   function automatic arb_state_t own_state(input client_id_t id);
      arb_state_t st;
      if (id == 1'b1) begin
         st = ST_OWN1;
      end else begin
         st = ST_OWN0;
      end
      return st;
   endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Tracks which client issued each accepted read until its data returns from memory.
module rd_tag_pipe
   import gray_pkg::*;
#(
   parameter int DEPTH = 1
)(
   input  logic clk,
   input  logic reset,
   input  logic i_vld,
   input  logic i_id,
   output logic o_tail_vld,
   output logic o_tail_id,
   output logic o_busy
);

   logic [DEPTH-1:0] r_vld;
   logic [DEPTH-1:0] r_id;
   logic             w_busy;

   // Tag shift register, flushed so pre-reset beats never produce read data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_vld <= {DEPTH{1'b0}};
         r_id  <= {DEPTH{1'b0}};
      end else begin
         r_vld[0] <= i_vld;
         r_id[0]  <= i_id;
         for (int k = 1; k < DEPTH; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_id[k]  <= r_id[k-1];
         end
      end
   end

   // Busy covers only stages that will still hold a read after the next edge.
   always_comb begin
      w_busy = 1'b0;
      for (int k = 0; k < DEPTH - 1; k++) begin
         w_busy = w_busy | r_vld[k];
      end
   end

   assign o_tail_vld = r_vld[DEPTH-1];
   assign o_tail_id  = r_id[DEPTH-1];
   assign o_busy     = w_busy;

endmodule

// File: rtl/gray_mem_arbiter.sv
// Round-robin, burst-bounded sharing of the gray-image memory read port between two
// pixel engines; routes read data back to its issuer and aggregates frame completion.
module gray_mem_arbiter
   import gray_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int READ_LAT  = 1
)(
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [PIX_W-1:0]  mem_data,
   input  logic              c0_req,
   input  logic [ADDR_W-1:0] c0_addr,
   output logic              c0_gnt,
   output logic              c0_rvalid,
   output logic [PIX_W-1:0]  c0_rdata,
   input  logic              c1_req,
   input  logic [ADDR_W-1:0] c1_addr,
   output logic              c1_gnt,
   output logic              c1_rvalid,
   output logic [PIX_W-1:0]  c1_rdata,
   input  logic              c0_done,
   input  logic              c1_done,
   output logic              finish
);

   localparam int               CNT_W    = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_burst_cnt;
   logic [CNT_W-1:0] w_burst_nxt;
   logic             r_rr_ptr;
   logic             w_rr_nxt;

   logic             w_req0;
   logic             w_req1;
   logic             w_win_vld;
   client_id_t       w_win_id;
   client_id_t       w_owner_id;
   logic             w_at_limit;
   logic             w_same_owner;
   logic             w_beat;

   logic             w_tail_vld;
   logic             w_tail_id;
   logic             w_pipe_busy;

   logic             r_c0_rvalid;
   logic             r_c1_rvalid;
   logic [PIX_W-1:0] r_c0_rdata;
   logic [PIX_W-1:0] r_c1_rdata;
   logic             r_finish;

   // A client that has finished its frame no longer competes for the port.
   assign w_req0     = c0_req & ~c0_done;
   assign w_req1     = c1_req & ~c1_done;
   assign w_at_limit = (r_burst_cnt == CNT_LAST);
   assign w_owner_id = (r_state == ST_OWN1);

   // Winner selection from current ownership, burst budget and round-robin pointer.
   always_comb begin
      w_win_vld = 1'b0;
      w_win_id  = 1'b0;
      case (r_state)
         ST_OWN0: begin
            if (w_req0 && !(w_req1 && w_at_limit)) begin
               w_win_vld = 1'b1;
               w_win_id  = 1'b0;
            end else if (w_req1) begin
               w_win_vld = 1'b1;
               w_win_id  = 1'b1;
            end else begin
               w_win_vld = 1'b0;
               w_win_id  = 1'b0;
            end
         end
         ST_OWN1: begin
            if (w_req1 && !(w_req0 && w_at_limit)) begin
               w_win_vld = 1'b1;
               w_win_id  = 1'b1;
            end else if (w_req0) begin
               w_win_vld = 1'b1;
               w_win_id  = 1'b0;
            end else begin
               w_win_vld = 1'b0;
               w_win_id  = 1'b0;
            end
         end
         default: begin
            if (w_req0 && w_req1) begin
               w_win_vld = 1'b1;
               w_win_id  = r_rr_ptr;
            end else if (w_req0 || w_req1) begin
               w_win_vld = 1'b1;
               w_win_id  = w_req1;
            end else begin
               w_win_vld = 1'b0;
               w_win_id  = 1'b0;
            end
         end
      endcase
   end

   assign w_beat       = w_win_vld & mem_ready;
   assign w_same_owner = (r_state != ST_IDLE) && (w_win_id == w_owner_id);

   assign mem_req  = w_win_vld;
   assign mem_addr = !w_win_vld ? {ADDR_W{1'b0}} : (w_win_id ? c1_addr : c0_addr);
   assign c0_gnt   = w_beat & (w_win_id == 1'b0);
   assign c1_gnt   = w_beat & (w_win_id == 1'b1);

   // Ownership only moves on an accepted beat; a stalled request freezes everything.
   always_comb begin
      w_state_nxt = r_state;
      w_burst_nxt = r_burst_cnt;
      w_rr_nxt    = r_rr_ptr;
      if (w_beat) begin
         w_state_nxt = own_state(w_win_id);
         w_rr_nxt    = ~w_win_id;
         if (!w_same_owner) begin
            w_burst_nxt = {CNT_W{1'b0}};
         end else if (w_at_limit) begin
            w_burst_nxt = r_burst_cnt;
         end else begin
            w_burst_nxt = r_burst_cnt + CNT_W'(1);
         end
      end else if (!w_win_vld) begin
         w_state_nxt = ST_IDLE;
         w_burst_nxt = {CNT_W{1'b0}};
      end else begin
         w_state_nxt = r_state;
         w_burst_nxt = r_burst_cnt;
      end
   end

   // Arbitration state registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_burst_cnt <= {CNT_W{1'b0}};
         r_rr_ptr    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_burst_cnt <= w_burst_nxt;
         r_rr_ptr    <= w_rr_nxt;
      end
   end

   rd_tag_pipe #(
      .DEPTH (READ_LAT)
   ) u_tag_pipe (
      .clk        (clk),
      .reset      (reset),
      .i_vld      (w_beat),
      .i_id       (w_win_id),
      .o_tail_vld (w_tail_vld),
      .o_tail_id  (w_tail_id),
      .o_busy     (w_pipe_busy)
   );

   // Read data capture and routing; the idle client's data register holds its last value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_c0_rvalid <= 1'b0;
         r_c1_rvalid <= 1'b0;
         r_c0_rdata  <= {PIX_W{1'b0}};
         r_c1_rdata  <= {PIX_W{1'b0}};
      end else begin
         r_c0_rvalid <= w_tail_vld & (w_tail_id == 1'b0);
         r_c1_rvalid <= w_tail_vld & (w_tail_id == 1'b1);
         if (w_tail_vld && (w_tail_id == 1'b0)) begin
            r_c0_rdata <= mem_data;
         end
         if (w_tail_vld && (w_tail_id == 1'b1)) begin
            r_c1_rdata <= mem_data;
         end
      end
   end

   // The read sitting at the pipe tail is delivered on the same edge finish can rise.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_finish <= 1'b0;
      end else begin
         r_finish <= r_finish | (c0_done & c1_done & ~w_pipe_busy & ~w_win_vld);
      end
   end

   assign c0_rvalid = r_c0_rvalid;
   assign c1_rvalid = r_c1_rvalid;
   assign c0_rdata  = r_c0_rdata;
   assign c1_rdata  = r_c1_rdata;
   assign finish    = r_finish;

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Randomized scoreboard bench for gray_mem_arbiter against a run-length arbitration model.
module tb_gray_mem_arbiter;

   localparam int MAX_BURST = 4;
   localparam int READ_LAT  = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic [13:0] mem_addr;
   logic        mem_ready;
   logic [7:0]  mem_data;
   logic        c0_req, c1_req;
   logic [13:0] c0_addr, c1_addr;
   logic        c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
   logic [7:0]  c0_rdata, c1_rdata;
   logic        c0_done, c1_done, finish;

   gray_mem_arbiter #(.MAX_BURST(MAX_BURST), .READ_LAT(READ_LAT)) dut (
      .clk(clk), .reset(reset),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
      .c0_req(c0_req), .c0_addr(c0_addr), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
      .c1_req(c1_req), .c1_addr(c1_addr), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
      .c0_done(c0_done), .c1_done(c1_done), .finish(finish)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit armed   = 1'b0;

   logic [7:0]  mem_arr [16384];
   logic [13:0] ml_addr [READ_LAT];

   typedef struct {
      bit         id;
      logic [7:0] data;
      int         due;
   } rsp_t;
   rsp_t sb[$];

   // model state: current owner, length of its current run, last winner
   bit m_own_vld = 1'b0;
   bit m_owner   = 1'b0;
   bit m_last    = 1'b1;
   int m_run     = 0;
   bit m_finish  = 1'b0;

   logic [7:0] x_rd0 = 8'd0;
   logic [7:0] x_rd1 = 8'd0;

   bit g0_seen = 1'b0, g1_seen = 1'b0;
   int rate0, rate1, rdy_rate;
   bit seq0, seq1;
   logic [13:0] a0_next, a1_next;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // memory: returns mem_arr[addr] READ_LAT cycles after the address was presented
   always @(posedge clk) begin
      ml_addr[0] <= mem_addr;
      for (int k = 1; k < READ_LAT; k++) ml_addr[k] <= ml_addr[k-1];
   end
   assign mem_data = mem_arr[ml_addr[READ_LAT-1]];

   always @(negedge clk) begin
      g0_seen = c0_gnt;
      g1_seen = c1_gnt;
   end

   // reference model: predicts grants and pushes expected read responses
   always @(negedge clk) begin : model
      bit r0, r1, pv, pid, beat;
      logic [13:0] ea;
      rsp_t e;
      #2;
      if (armed) begin
         r0 = c0_req && !c0_done;
         r1 = c1_req && !c1_done;
         pv = r0 || r1;
         if (r0 && r1) begin
            if (m_own_vld) pid = (m_run >= MAX_BURST) ? !m_owner : m_owner;
            else           pid = !m_last;
         end else begin
            pid = r1;
         end
         ea   = !pv ? 14'd0 : (pid ? c1_addr : c0_addr);
         beat = pv && mem_ready;
         check("mem_req",  32'(mem_req),  32'(pv));
         check("mem_addr", 32'(mem_addr), 32'(ea));
         check("c0_gnt",   32'(c0_gnt),   32'(beat && !pid));
         check("c1_gnt",   32'(c1_gnt),   32'(beat && pid));
         check("finish",   32'(finish),   32'(m_finish));
         if (!reset) begin
            m_own_vld = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_run = 0; m_finish = 1'b0;
            sb.delete();
         end else begin
            if (c0_done && c1_done && !pv && (sb.size() == 0 || sb[$].due <= cyc + 1))
               m_finish = 1'b1;
            if (beat) begin
               e.id = pid; e.data = mem_arr[ea]; e.due = cyc + READ_LAT + 1;
               sb.push_back(e);
               m_run     = (m_own_vld && m_owner == pid) ? m_run + 1 : 1;
               m_owner   = pid;
               m_own_vld = 1'b1;
               m_last    = pid;
            end else if (!pv) begin
               m_own_vld = 1'b0;
            end
         end
      end
   end

   // monitor: pops expected responses and compares read-data outputs
   always @(negedge clk) begin : monitor
      rsp_t e;
      if (armed) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("c0_rvalid", 32'(c0_rvalid), 32'(!e.id));
            check("c1_rvalid", 32'(c1_rvalid), 32'(e.id));
            if (e.id) x_rd1 = e.data;
            else      x_rd0 = e.data;
         end else begin
            check("c0_rvalid_idle", 32'(c0_rvalid), 32'd0);
            check("c1_rvalid_idle", 32'(c1_rvalid), 32'd0);
         end
         check("c0_rdata", 32'(c0_rdata), 32'(x_rd0));
         check("c1_rdata", 32'(c1_rdata), 32'(x_rd1));
         if (!reset) begin
            x_rd0 = 8'd0;
            x_rd1 = 8'd0;
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (!(c0_req && !g0_seen)) begin
            c0_req = (int'($urandom_range(0, 99)) < rate0);
            c0_addr = seq0 ? a0_next : 14'($urandom);
            if (c0_req) a0_next = a0_next + 14'd1;
         end
         if (!(c1_req && !g1_seen)) begin
            c1_req = (int'($urandom_range(0, 99)) < rate1);
            c1_addr = seq1 ? a1_next : 14'($urandom);
            if (c1_req) a1_next = a1_next + 14'd1;
         end
         mem_ready = (int'($urandom_range(0, 99)) < rdy_rate);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1; reset = 1'b0;
      @(posedge clk); #1; reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem_arr[i] = 8'($urandom);
      reset = 1'b0; mem_ready = 1'b0;
      c0_req = 1'b0; c1_req = 1'b0; c0_addr = 14'd0; c1_addr = 14'd0;
      c0_done = 1'b0; c1_done = 1'b0;
      rate0 = 0; rate1 = 0; rdy_rate = 100;
      seq0 = 1'b1; seq1 = 1'b1; a0_next = 14'd0; a1_next = 14'd100;
      @(posedge clk); #1; armed = 1'b1;
      @(posedge clk); #1; reset = 1'b1;

      // c0 alone, sequential addresses 0..9
      rate0 = 100; step(10);
      rate0 = 0;   step(4);

      // both requesting straight from reset, then a 3-cycle memory stall
      pulse_reset();
      rate0 = 100; rate1 = 100; step(20);
      rdy_rate = 0;   step(3);
      rdy_rate = 100; step(8);

      // c0 requests intermittently so it drops ownership mid-burst
      rate0 = 40; step(40);

      // reset with reads in flight
      rate0 = 100; step(3);
      pulse_reset();
      step(6);

      repeat (8) begin
         rate0    = int'($urandom_range(0, 100));
         rate1    = int'($urandom_range(0, 100));
         rdy_rate = int'($urandom_range(30, 100));
         seq0     = 1'($urandom_range(0, 1));
         seq1     = 1'($urandom_range(0, 1));
         step(50);
      end

      // completion: c0 finishes first, then c1
      rate0 = 80; rate1 = 80; rdy_rate = 100;
      c0_done = 1'b1; step(20);
      c1_done = 1'b1; step(12);

      check("sb_drained", 32'(sb.size()), 32'd0);
      check("finish_final", 32'(finish), 32'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
